// File: rtl/regfile_wb_arbiter.sv
// Write-port owner for the 32x32 register file: clears r1..r31 after reset or on
// request, then round-robins writeback requests from the ALU (A) and load unit (B).
module regfile_wb_arbiter #(
  parameter int CLEAR_ON_RESET = 1,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init_req,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_reg,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_reg,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  reg_wren,
  output logic [ADDR_WIDTH-1:0] w_reg0,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  init_done
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = '1;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic   RESET_DONE  = (CLEAR_ON_RESET == 0);

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] cnt, cnt_d;
  logic                  last_grant_b, last_grant_b_d;
  logic                  reg_wren_d;
  logic [ADDR_WIDTH-1:0] w_reg0_d;
  logic [DATA_WIDTH-1:0] w_data_d;
  logic                  init_done_d;
  logic                  grant_a, grant_b;
  logic                  init_pulse;

  assign init_pulse = (CLEAR_ON_RESET != 0) && init_req;
  assign a_ready    = grant_a;
  assign b_ready    = grant_b;

  // Next-state, arbitration and next write-port values; everything is registered below
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    last_grant_b_d = last_grant_b;
    reg_wren_d     = 1'b0;
    w_reg0_d       = w_reg0;
    w_data_d       = w_data;
    init_done_d    = init_done;
    grant_a        = 1'b0;
    grant_b        = 1'b0;
    case (state)
      ST_INIT: begin
        reg_wren_d = 1'b1;
        w_reg0_d   = cnt;
        w_data_d   = '0;
        if (cnt == CNT_LAST) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          cnt_d       = CNT_FIRST;
        end else begin
          cnt_d = cnt + CNT_FIRST;
        end
      end
      ST_RUN: begin
        if (init_pulse) begin
          state_d     = ST_INIT;
          init_done_d = 1'b0;
          cnt_d       = CNT_FIRST;
        end else begin
          // On contention the requester that did not win last time gets the port
          if (a_valid && (!b_valid || last_grant_b)) begin
            grant_a = 1'b1;
          end else if (b_valid) begin
            grant_b = 1'b1;
          end
          if (grant_a) begin
            w_reg0_d       = a_reg;
            w_data_d       = a_data;
            reg_wren_d     = (a_reg != '0);
            last_grant_b_d = 1'b0;
          end else if (grant_b) begin
            w_reg0_d       = b_reg;
            w_data_d       = b_data;
            reg_wren_d     = (b_reg != '0);
            last_grant_b_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RESET_STATE;
      cnt          <= CNT_FIRST;
      last_grant_b <= 1'b1;
      reg_wren     <= 1'b0;
      w_reg0       <= '0;
      w_data       <= '0;
      init_done    <= RESET_DONE;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      last_grant_b <= last_grant_b_d;
      reg_wren     <= reg_wren_d;
      w_reg0       <= w_reg0_d;
      w_data       <= w_data_d;
      init_done    <= init_done_d;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- After reset, sequences a clear of r1..r31 to zero, then shares the write port between two writeback requesters: A (ALU writeback) and B (load/memory writeback).
- Arbitration is round-robin with valid/ready handshakes.
- Outputs are registered and drive the register file's reg_wren, w_reg0 and w_data directly.

Parameters:
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset and on init_req; 0 = enter RUN directly and ignore init_req.
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register select width; the clear counter covers 1..(2^ADDR_WIDTH-1).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- init_req  in  1  one-cycle pulse; re-runs the clear sequence (RUN state only)
- a_valid  in  1  requester A has a write pending
- a_reg  in  ADDR_WIDTH  requester A destination register
- a_data  in  DATA_WIDTH  requester A write data
- a_ready  out  1  A accepted this cycle (combinational)
- b_valid  in  1  requester B has a write pending
- b_reg  in  ADDR_WIDTH  requester B destination register
- b_data  in  DATA_WIDTH  requester B write data
- b_ready  out  1  B accepted this cycle (combinational)
- reg_wren  out  1  register file write enable (registered)
- w_reg0  out  ADDR_WIDTH  register file write select (registered)
- w_data  out  DATA_WIDTH  register file write data (registered)
- init_done  out  1  high while in RUN (registered)

Behaviour:
- Reset (asynchronous, reset_n=0):
  - reg_wren=0, w_reg0=0, w_data=0.
  - init_done = !CLEAR_ON_RESET.
  - State = INIT when CLEAR_ON_RESET=1, otherwise RUN; clear counter = 1; last_grant = B.
- States are INIT and RUN.
- INIT:
  - a_ready = b_ready = 0.
  - Each edge registers reg_wren=1, w_reg0=cnt, w_data=0, then cnt increments.
  - On the edge that registers cnt=31: state -> RUN, init_done=1, cnt reloads to 1.
  - Clearing from reset takes exactly 31 edges; r0 is never written.
- RUN arbitration:
  - Only A valid -> a_ready=1.
  - Only B valid -> b_ready=1.
  - Both valid -> grant the requester that is not last_grant.
  - At most one ready is high per cycle.
  - last_grant updates on every grant.
- Acceptance:
  - A request is accepted when valid && ready.
  - On the next edge, w_reg0/w_data take the winner's reg/data and reg_wren=1.
  - Latency is 1 cycle from acceptance to the write strobe.
  - Requesters must hold valid/reg/data stable until accepted.
- Writes to register 0:
  - The request is accepted (ready=1), last_grant updates, w_reg0/w_data load, but reg_wren=0.
- No grant in a cycle -> next edge reg_wren=0; w_reg0/w_data hold their previous values.
- init_req in RUN:
  - Ready outputs are forced to 0 in that cycle; no request is accepted.
  - Next edge: state=INIT, init_done=0, reg_wren=0.
  - The write accepted in the previous cycle is already registered, so it still completes.
  - Clearing then proceeds as above: 31 write strobes, init_done rising on the edge that writes r31.
- init_req in INIT is ignored; the counter is not restarted.
- init_req is ignored entirely when CLEAR_ON_RESET=0.
- Reset asserted mid-INIT or mid-RUN: all state returns to reset values immediately. The clear restarts from r1 after release; any in-flight write is dropped.
- No combinational path from any input to reg_wren, w_reg0 or w_data.

Test Plan:
- Clear from reset: release reset with CLEAR_ON_RESET=1 and no requests -> 31 consecutive strobes with w_reg0=1..31 and w_data=0; init_done=1 on the edge of r31; no ready asserted during the sequence.
- Single requester: in RUN, a_valid=1, a_reg=5, a_data=32'hDEADBEEF held one cycle -> a_ready=1 that cycle; next edge reg_wren=1, w_reg0=5, w_data=32'hDEADBEEF; following cycle reg_wren=0.
- Round-robin: A (r8, 1) and B (r9, 2) both held valid, first cycle after init -> grant order A,B,A,B; strobes r8,r9,r8,r9 on successive edges with no idle cycle.
- Register 0: b_valid, b_reg=0, b_data=32'h1234 -> b_ready=1; no reg_wren pulse; next A/B contention grants A.
- init_req mid-traffic: pulse init_req in the cycle after an A acceptance of r3 -> r3 write strobe completes, no ready in the pulse cycle, then 31 clear strobes; init_done low, then high.
- Reset mid-INIT: assert reset_n=0 after the r10 clear strobe -> reg_wren=0 and init_done=0 immediately; after release the clear restarts at w_reg0=1.
